// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_pkg                                                         |
// | Purpose  : Shared UART constants, divisor helper and RX state encoding.     |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package uart_pkg;

    localparam int          DATA_BITS   = 8;
    localparam int          OVERSAMPLE  = 16;
    localparam int          c_DIV_W     = 10;

    localparam int unsigned c_BAUD_9600   = 9600;
    localparam int unsigned c_BAUD_19200  = 19200;
    localparam int unsigned c_BAUD_57600  = 57600;
    localparam int unsigned c_BAUD_115200 = 115200;

    // Rounded divisor; yields 651/326/109/54 at 100 MHz and 326/163/54/27 at 50 MHz.
    function automatic int unsigned div_round(input int unsigned clk_hz,
                                              input int unsigned baud);
        int unsigned w_den;
        w_den = baud * OVERSAMPLE;
        return (clk_hz + w_den / 2) / w_den;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_receiver_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_receiver_if                                                 |
// | Purpose  : CPU-side receive register bus of the UART receiver.             |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface uart_receiver_if;
    logic        read_enable;
    logic [31:0] RCREG;
    logic        RCIF;
    logic        OERR;
    logic        FERR;

    modport master (output read_enable, input RCREG, RCIF, OERR, FERR);
    modport slave  (input read_enable, output RCREG, RCIF, OERR, FERR);
endinterface
`default_nettype wire

// File: rtl/uart_rx_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_rx_tick_gen                                                 |
// | Purpose  : 16x oversampling tick from baud select and clock-mode select.   |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module uart_rx_tick_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_en_50mhz,
    input  logic [1:0] i_baud_sel,
    input  logic       i_clr,
    output logic       o_tick
);

    localparam int unsigned          c_HZ_HALF = CLK_HZ / 2;
    localparam logic [c_DIV_W-1:0]   c_ONE     = c_DIV_W'(1);

    logic [c_DIV_W-1:0] w_div;
    logic [c_DIV_W-1:0] r_cnt;
    logic [2:0]         r_cfg;
    logic               w_cfg_chg;

    always_comb begin
        w_div = c_ONE;
        case ({i_en_50mhz, i_baud_sel})
            3'b000:  w_div = c_DIV_W'(div_round(CLK_HZ,    c_BAUD_9600));
            3'b001:  w_div = c_DIV_W'(div_round(CLK_HZ,    c_BAUD_19200));
            3'b010:  w_div = c_DIV_W'(div_round(CLK_HZ,    c_BAUD_57600));
            3'b011:  w_div = c_DIV_W'(div_round(CLK_HZ,    c_BAUD_115200));
            3'b100:  w_div = c_DIV_W'(div_round(c_HZ_HALF, c_BAUD_9600));
            3'b101:  w_div = c_DIV_W'(div_round(c_HZ_HALF, c_BAUD_19200));
            3'b110:  w_div = c_DIV_W'(div_round(c_HZ_HALF, c_BAUD_57600));
            default: w_div = c_DIV_W'(div_round(c_HZ_HALF, c_BAUD_115200));
        endcase
    end

    assign w_cfg_chg = (r_cfg != {i_en_50mhz, i_baud_sel});
    assign o_tick    = (r_cnt >= (w_div - c_ONE));

    // A rate change restarts the phase so the new divisor never sees a stale count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_cfg <= '0;
        end else begin
            r_cfg <= {i_en_50mhz, i_baud_sel};
            if (i_clr || w_cfg_chg || o_tick)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + c_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_receiver                                                    |
// | Purpose  : 8N1 UART receiver with 16x oversampling and 2-entry RX FIFO.    |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            EN_50MHz,
    input  logic [1:0]      baud_sel,
    input  logic            SPEN,
    input  logic            CREN,
    input  logic            RX,
    uart_receiver_if.slave  bus
);

    localparam logic [3:0] c_SC_MID  = 4'd8;
    localparam logic [3:0] c_SC_VOTE = 4'd9;
    localparam logic [3:0] c_SC_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] c_BIT_LAST = 3'(DATA_BITS - 1);

    logic                 r_rx_meta, r_rx_sync, r_rx_prev;
    rx_state_t            r_state, w_nxt;
    logic [3:0]           r_sc;
    logic [2:0]           r_bit_cnt;
    logic [1:0]           r_samp;
    logic [DATA_BITS-1:0] r_shift;
    logic [8:0]           r_ent0, r_ent1;
    logic                 r_vld0, r_vld1, r_oerr;

    logic w_tick, w_clr, w_bit_en, w_push_req, w_enable, w_fall, w_maj;
    logic w_pop, w_push, w_ovr;
    logic [8:0] w_entry;

    uart_rx_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
        .clk        (clk),
        .reset      (reset),
        .i_en_50mhz (EN_50MHz),
        .i_baud_sel (baud_sel),
        .i_clr      (w_clr),
        .o_tick     (w_tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= RX;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    assign w_enable = SPEN && CREN;
    assign w_fall   = r_rx_prev && !r_rx_sync;
    // Two stored samples plus the current one give the 3-sample vote.
    assign w_maj    = (r_samp[1] & r_samp[0]) | (r_samp[1] & r_rx_sync) | (r_samp[0] & r_rx_sync);
    assign w_entry  = {~w_maj, r_shift};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_nxt;
    end

    // START spans the whole start bit so every DATA period begins at sc=0.
    always_comb begin
        w_nxt      = r_state;
        w_clr      = 1'b0;
        w_bit_en   = 1'b0;
        w_push_req = 1'b0;
        if (!w_enable) begin
            w_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_fall) begin
                        w_nxt = ST_START;
                        w_clr = 1'b1;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        if (r_sc == c_SC_MID && r_rx_sync)
                            w_nxt = ST_IDLE;
                        else if (r_sc == c_SC_LAST)
                            w_nxt = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        w_bit_en = (r_sc == c_SC_VOTE);
                        if (r_sc == c_SC_LAST && r_bit_cnt == c_BIT_LAST)
                            w_nxt = ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_tick && r_sc == c_SC_MID) begin
                        w_nxt      = ST_IDLE;
                        w_push_req = 1'b1;
                    end
                end
                default: w_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sc      <= '0;
            r_bit_cnt <= '0;
            r_samp    <= 2'b11;
            r_shift   <= '0;
        end else begin
            if (w_clr) begin
                r_sc      <= '0;
                r_bit_cnt <= '0;
            end else if (w_tick && r_state != ST_IDLE) begin
                r_sc   <= r_sc + 4'd1;
                r_samp <= {r_samp[0], r_rx_sync};
                if (r_state == ST_DATA && r_sc == c_SC_LAST)
                    r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_bit_en)
                r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
        end
    end

    assign w_pop  = bus.read_enable && r_vld0;
    assign w_push = w_push_req && !r_oerr && (!r_vld1 || w_pop);
    assign w_ovr  = w_push_req && !r_oerr && r_vld1 && !w_pop;

    // Head entry is kept at zero while empty so the outputs are plain register taps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ent0 <= '0;
            r_ent1 <= '0;
            r_vld0 <= 1'b0;
            r_vld1 <= 1'b0;
        end else if (!SPEN) begin
            r_ent0 <= '0;
            r_ent1 <= '0;
            r_vld0 <= 1'b0;
            r_vld1 <= 1'b0;
        end else if (w_pop) begin
            if (w_push && r_vld1) begin
                r_ent0 <= r_ent1;
                r_ent1 <= w_entry;
            end else if (w_push) begin
                r_ent0 <= w_entry;
            end else begin
                r_ent0 <= r_vld1 ? r_ent1 : 9'd0;
                r_vld0 <= r_vld1;
                r_ent1 <= '0;
                r_vld1 <= 1'b0;
            end
        end else if (w_push) begin
            if (!r_vld0) begin
                r_ent0 <= w_entry;
                r_vld0 <= 1'b1;
            end else begin
                r_ent1 <= w_entry;
                r_vld1 <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_oerr <= 1'b0;
        else if (!w_enable)
            r_oerr <= 1'b0;
        else if (w_ovr)
            r_oerr <= 1'b1;
    end

    assign bus.RCREG = {23'b0, r_ent0};
    assign bus.RCIF  = r_vld0;
    assign bus.FERR  = r_ent0[8];
    assign bus.OERR  = r_oerr;

endmodule
`default_nettype wire
